// File: rtl/float_compare_pipe_if.sv
// Operand/result stream bundle for the FP compare/select pipe; widths follow the
// same EXP_W/MAN_W split as the unit it connects to.
interface float_compare_pipe_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   op;
    logic         in_valid;
    logic         in_ready;
    logic         out_valid;
    logic         out_ready;
    logic         flag;
    logic [W-1:0] value;
    logic         unordered;

    modport master (
        output a, b, op, in_valid, out_ready,
        input  in_ready, out_valid, flag, value, unordered
    );

    modport slave (
        input  a, b, op, in_valid, out_ready,
        output in_ready, out_valid, flag, value, unordered
    );
endinterface

// File: rtl/float_compare_pipe.sv
// Pipelined FP compare (EQ/LT/LE/GT/GE) and MIN/MAX select; 2-cycle latency, 1 op/cycle.
// Valid/ready both sides; a stall freezes both stages while a stage-1 bubble still fills.
module float_compare_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 reset,
    float_compare_pipe_if.slave  io
);
    localparam int W = 1 + EXP_W + MAN_W;

    localparam logic [2:0] OP_EQ  = 3'd0;
    localparam logic [2:0] OP_LT  = 3'd1;
    localparam logic [2:0] OP_LE  = 3'd2;
    localparam logic [2:0] OP_GT  = 3'd3;
    localparam logic [2:0] OP_GE  = 3'd4;
    localparam logic [2:0] OP_MIN = 3'd5;
    localparam logic [2:0] OP_MAX = 3'd6;

    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef struct packed {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         a_nan;
        logic         b_nan;
        logic         both_zero;
        logic         mag_lt;
        logic         mag_eq;
    } s1_t;

    s1_t          s1_d;
    s1_t          s1_q;
    logic         s1_valid;
    logic         s2_valid;
    logic         flag_q;
    logic [W-1:0] value_q;
    logic         unord_q;

    logic         adv1;
    logic         adv2;
    logic         in_ready;

    logic [EXP_W-1:0] a_exp;
    logic [EXP_W-1:0] b_exp;
    logic [MAN_W-1:0] a_man;
    logic [MAN_W-1:0] b_man;
    logic [W-2:0]     a_mag;
    logic [W-2:0]     b_mag;

    assign adv2     = ~s2_valid | io.out_ready;
    assign adv1     = ~s1_valid | adv2;
    assign in_ready = adv1 & ~reset;

    assign io.in_ready  = in_ready;
    assign io.out_valid = s2_valid;
    assign io.flag      = flag_q;
    assign io.value     = value_q;
    assign io.unordered = unord_q;

    assign a_exp = io.a[W-2 -: EXP_W];
    assign b_exp = io.b[W-2 -: EXP_W];
    assign a_man = io.a[MAN_W-1:0];
    assign b_man = io.b[MAN_W-1:0];
    // {exp, man} orders every non-NaN magnitude, subnormals and infinity included.
    assign a_mag = io.a[W-2:0];
    assign b_mag = io.b[W-2:0];

    always_comb begin
        s1_d           = '0;
        s1_d.op        = io.op;
        s1_d.a         = io.a;
        s1_d.b         = io.b;
        s1_d.a_nan     = (&a_exp) & (|a_man);
        s1_d.b_nan     = (&b_exp) & (|b_man);
        s1_d.both_zero = (a_mag == '0) & (b_mag == '0);
        s1_d.mag_lt    = a_mag < b_mag;
        s1_d.mag_eq    = a_mag == b_mag;
    end

    logic         sa;
    logic         sb;
    logic         unord_d;
    logic         eq;
    logic         lt;
    logic         min_a;
    logic         max_a;
    logic [W-1:0] min_v;
    logic [W-1:0] max_v;
    logic         flag_d;
    logic [W-1:0] value_d;

    always_comb begin
        sa      = s1_q.a[W-1];
        sb      = s1_q.b[W-1];
        unord_d = s1_q.a_nan | s1_q.b_nan;
        eq      = s1_q.both_zero | ((sa == sb) & s1_q.mag_eq);
        lt      = 1'b0;
        if (s1_q.both_zero) begin
            lt = 1'b0;
        end else if (sa != sb) begin
            lt = sa;
        end else if (!sa) begin
            lt = s1_q.mag_lt;
        end else begin
            lt = ~s1_q.mag_lt & ~s1_q.mag_eq;
        end

        // Opposite-signed zeros compare equal but MIN/MAX must still pick by sign.
        if (s1_q.both_zero && (sa != sb)) begin
            min_a = sa;
            max_a = sb;
        end else begin
            min_a = lt | eq;
            max_a = ~lt;
        end

        if (s1_q.a_nan && s1_q.b_nan) begin
            min_v = QNAN;
            max_v = QNAN;
        end else if (s1_q.a_nan) begin
            min_v = s1_q.b;
            max_v = s1_q.b;
        end else if (s1_q.b_nan) begin
            min_v = s1_q.a;
            max_v = s1_q.a;
        end else begin
            min_v = min_a ? s1_q.a : s1_q.b;
            max_v = max_a ? s1_q.a : s1_q.b;
        end

        flag_d  = 1'b0;
        value_d = '0;
        case (s1_q.op)
            OP_EQ:   flag_d = ~unord_d & eq;
            OP_LT:   flag_d = ~unord_d & lt;
            OP_LE:   flag_d = ~unord_d & (lt | eq);
            OP_GT:   flag_d = ~unord_d & ~lt & ~eq;
            OP_GE:   flag_d = ~unord_d & ~lt;
            OP_MIN:  value_d = min_v;
            OP_MAX:  value_d = max_v;
            default: begin
                flag_d  = 1'b0;
                value_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            flag_q   <= 1'b0;
            value_q  <= '0;
            unord_q  <= 1'b0;
        end else begin
            if (adv1) begin
                s1_valid <= io.in_valid;
            end
            if (adv2) begin
                s2_valid <= s1_valid;
            end
            if (adv2 && s1_valid) begin
                flag_q  <= flag_d;
                value_q <= value_d;
                unord_q <= unord_d;
            end
        end
    end

    // Stage-1 payload needs no reset: it is only consumed under s1_valid.
    always_ff @(posedge clk) begin
        if (io.in_valid && in_ready) begin
            s1_q <= s1_d;
        end
    end
endmodule

// File: tb/tb_float_compare_pipe.sv
// Directed bench for float_compare_pipe: single and half precision instances,
// table-driven streams plus hand-written stall and reset-flush sequences.
module tb_float_compare_pipe;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    float_compare_pipe_if #(.EXP_W(8), .MAN_W(23)) f_if ();
    float_compare_pipe_if #(.EXP_W(5), .MAN_W(10)) h_if ();

    float_compare_pipe #(.EXP_W(8), .MAN_W(23)) u_full (.clk(clk), .reset(reset), .io(f_if.slave));
    float_compare_pipe #(.EXP_W(5), .MAN_W(10)) u_half (.clk(clk), .reset(reset), .io(h_if.slave));

    int checks = 0;
    int failures = 0;

    typedef struct {
        bit          sel;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic        fl;
        logic [31:0] val;
        logic        un;
    } vec_t;

    vec_t tbl[$];

    task automatic addv(input bit sel, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] op, input logic fl, input logic [31:0] val,
                        input logic un);
        vec_t v;
        v.sel = sel; v.a = a; v.b = b; v.op = op; v.fl = fl; v.val = val; v.un = un;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] got=%h want=%h", nm, idx, act, exp);
        end
    endtask

    task automatic put(input bit sel, input logic v, input logic [31:0] a,
                       input logic [31:0] b, input logic [2:0] op);
        if (sel) begin
            h_if.in_valid = v; h_if.a = a[15:0]; h_if.b = b[15:0]; h_if.op = op;
        end else begin
            f_if.in_valid = v; f_if.a = a; f_if.b = b; f_if.op = op;
        end
    endtask

    task automatic get_out(input bit sel, output logic ov, output logic ir,
                           output logic fl, output logic un, output logic [31:0] val);
        if (sel) begin
            ov = h_if.out_valid; ir = h_if.in_ready; fl = h_if.flag;
            un = h_if.unordered; val = {16'h0, h_if.value};
        end else begin
            ov = f_if.out_valid; ir = f_if.in_ready; fl = f_if.flag;
            un = f_if.unordered; val = f_if.value;
        end
    endtask

    // Back-to-back stream from an idle pipe: vector c must show exactly two edges after acceptance.
    task automatic run_stream(input bit sel, input int lo, input int hi);
        int n;
        logic ov, ir, fl, un;
        logic [31:0] val;
        n = hi - lo + 1;
        for (int c = 0; c < n + 2; c++) begin
            @(negedge clk);
            get_out(sel, ov, ir, fl, un, val);
            if (c >= 2) begin
                chk("str_valid", lo + c - 2, 32'(ov), 32'(1'b1));
                chk("str_flag",  lo + c - 2, 32'(fl), 32'(tbl[lo + c - 2].fl));
                chk("str_value", lo + c - 2, val, tbl[lo + c - 2].val);
                chk("str_unord", lo + c - 2, 32'(un), 32'(tbl[lo + c - 2].un));
            end else begin
                chk("str_lat_idle", lo + c, 32'(ov), 32'(1'b0));
            end
            if (c < n) begin
                chk("str_in_ready", lo + c, 32'(ir), 32'(1'b1));
                put(sel, 1'b1, tbl[lo + c].a, tbl[lo + c].b, tbl[lo + c].op);
            end else begin
                put(sel, 1'b0, 32'h0, 32'h0, 3'd0);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic ov, ir, fl, un;
        logic [31:0] val;
        int hlo, hhi, flo, fhi;
        int idx[4];
        int sent, rcv;

        // Single precision: scenario 2 stream, then NaN, signed zero, infinity, reserved op.
        flo = 0;
        addv(0, 32'h40400000, 32'h40000000, 3'd3, 1, 32'h0, 0);
        addv(0, 32'hC0400000, 32'hC0000000, 3'd1, 1, 32'h0, 0);
        addv(0, 32'h00000000, 32'h80000000, 3'd0, 1, 32'h0, 0);
        addv(0, 32'h3F800000, 32'h3F800000, 3'd2, 1, 32'h0, 0);
        addv(0, 32'hC0000000, 32'h40000000, 3'd4, 0, 32'h0, 0);
        addv(0, 32'h40400000, 32'h40000000, 3'd5, 0, 32'h40000000, 0);
        addv(0, 32'hC0400000, 32'hC0000000, 3'd6, 0, 32'hC0000000, 0);
        addv(0, 32'h40000000, 32'hC0000000, 3'd1, 0, 32'h0, 0);
        addv(0, 32'h7FC00001, 32'h3F800000, 3'd3, 0, 32'h0, 1);
        addv(0, 32'h7FC00001, 32'h3F800000, 3'd2, 0, 32'h0, 1);
        addv(0, 32'h7FC00001, 32'h3F800000, 3'd5, 0, 32'h3F800000, 1);
        addv(0, 32'h7FC00001, 32'h7FC00001, 3'd6, 0, 32'h7FC00000, 1);
        addv(0, 32'h7FC00001, 32'h7FC00001, 3'd0, 0, 32'h0, 1);
        addv(0, 32'h00000000, 32'h80000000, 3'd5, 0, 32'h80000000, 0);
        addv(0, 32'h80000000, 32'h00000000, 3'd6, 0, 32'h00000000, 0);
        addv(0, 32'h7F800000, 32'h7F7FFFFF, 3'd3, 1, 32'h0, 0);
        addv(0, 32'hFF800000, 32'h00000001, 3'd1, 1, 32'h0, 0);
        addv(0, 32'h40000000, 32'h3F800000, 3'd7, 0, 32'h0, 0);
        addv(0, 32'h7FC00001, 32'h00000000, 3'd7, 0, 32'h0, 1);
        addv(0, 32'h80000000, 32'h00000000, 3'd5, 0, 32'h80000000, 0);
        addv(0, 32'h00000000, 32'h80000000, 3'd6, 0, 32'h00000000, 0);
        addv(0, 32'hFF800000, 32'hFF800000, 3'd4, 1, 32'h0, 0);
        addv(0, 32'h3F800000, 32'h7FC00001, 3'd6, 0, 32'h3F800000, 1);
        fhi = tbl.size() - 1;
        // Half precision repeats of scenarios 2-4.
        hlo = tbl.size();
        addv(1, 32'h4200, 32'h4000, 3'd3, 1, 32'h0, 0);
        addv(1, 32'hC200, 32'hC000, 3'd1, 1, 32'h0, 0);
        addv(1, 32'h0000, 32'h8000, 3'd0, 1, 32'h0, 0);
        addv(1, 32'h3C00, 32'h3C00, 3'd2, 1, 32'h0, 0);
        addv(1, 32'h4200, 32'h4000, 3'd5, 0, 32'h4000, 0);
        addv(1, 32'hC200, 32'hC000, 3'd6, 0, 32'hC000, 0);
        addv(1, 32'h7E01, 32'h3C00, 3'd3, 0, 32'h0, 1);
        addv(1, 32'h7E01, 32'h3C00, 3'd2, 0, 32'h0, 1);
        addv(1, 32'h7E01, 32'h3C00, 3'd5, 0, 32'h3C00, 1);
        addv(1, 32'h7E01, 32'h7E01, 3'd6, 0, 32'h7E00, 1);
        addv(1, 32'h0000, 32'h8000, 3'd5, 0, 32'h8000, 0);
        addv(1, 32'h8000, 32'h0000, 3'd6, 0, 32'h0000, 0);
        addv(1, 32'h7C00, 32'h7BFF, 3'd3, 1, 32'h0, 0);
        addv(1, 32'hFC00, 32'h0001, 3'd1, 1, 32'h0, 0);
        hhi = tbl.size() - 1;

        reset = 1'b1;
        put(0, 1'b0, 32'h0, 32'h0, 3'd0);
        put(1, 1'b0, 32'h0, 32'h0, 3'd0);
        f_if.out_ready = 1'b1;
        h_if.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            get_out(s[0], ov, ir, fl, un, val);
            chk("rst_in_ready", s, 32'(ir), 32'(1'b0));
            chk("rst_out_valid", s, 32'(ov), 32'(1'b0));
            chk("rst_flag", s, 32'(fl), 32'(1'b0));
            chk("rst_value", s, val, 32'h0);
            chk("rst_unord", s, 32'(un), 32'(1'b0));
        end
        reset = 1'b0;
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            get_out(s[0], ov, ir, fl, un, val);
            chk("post_rst_in_ready", s, 32'(ir), 32'(1'b1));
            chk("post_rst_out_valid", s, 32'(ov), 32'(1'b0));
        end

        run_stream(0, flo, fhi);
        repeat (3) @(negedge clk);

        // Backpressure: out_ready low for 5 cycles while the source keeps offering.
        idx[0] = 5; idx[1] = 6; idx[2] = 0; idx[3] = 10;
        sent = 0;
        rcv = 0;
        f_if.out_ready = 1'b0;
        for (int cyc = 0; cyc < 40 && rcv < 4; cyc++) begin
            @(negedge clk);
            if (cyc == 5) begin
                get_out(0, ov, ir, fl, un, val);
                chk("bp_accepted", 0, 32'(sent), 32'd2);
                chk("bp_in_ready_stalled", 0, 32'(ir), 32'(1'b0));
                f_if.out_ready = 1'b1;
                #1;
            end
            get_out(0, ov, ir, fl, un, val);
            if (cyc >= 2 && cyc < 5) begin
                chk("bp_hold_valid", cyc, 32'(ov), 32'(1'b1));
            end
            if (ov) begin
                if (f_if.out_ready) begin
                    chk("bp_drain_flag", rcv, 32'(fl), 32'(tbl[idx[rcv]].fl));
                    chk("bp_drain_value", rcv, val, tbl[idx[rcv]].val);
                    chk("bp_drain_unord", rcv, 32'(un), 32'(tbl[idx[rcv]].un));
                    rcv++;
                end else begin
                    chk("bp_hold_flag", cyc, 32'(fl), 32'(tbl[idx[0]].fl));
                    chk("bp_hold_value", cyc, val, tbl[idx[0]].val);
                    chk("bp_hold_unord", cyc, 32'(un), 32'(tbl[idx[0]].un));
                end
            end
            if (sent < 4) begin
                put(0, 1'b1, tbl[idx[sent]].a, tbl[idx[sent]].b, tbl[idx[sent]].op);
                if (ir) sent++;
            end else begin
                put(0, 1'b0, 32'h0, 32'h0, 3'd0);
            end
        end
        chk("bp_received", 0, 32'(rcv), 32'd4);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("bp_no_dup", k, 32'(f_if.out_valid), 32'(1'b0));
        end

        // Reset flush with two ops in flight.
        @(negedge clk);
        put(0, 1'b1, tbl[0].a, tbl[0].b, tbl[0].op);
        @(negedge clk);
        put(0, 1'b1, tbl[5].a, tbl[5].b, tbl[5].op);
        @(negedge clk);
        chk("rst_inflight_visible", 0, 32'(f_if.out_valid), 32'(1'b1));
        put(0, 1'b0, 32'h0, 32'h0, 3'd0);
        f_if.out_ready = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("rst_flush_valid", 0, 32'(f_if.out_valid), 32'(1'b0));
        chk("rst_flush_in_ready", 0, 32'(f_if.in_ready), 32'(1'b0));
        reset = 1'b0;
        f_if.out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("rst_no_stale_out", k, 32'(f_if.out_valid), 32'(1'b0));
        end

        run_stream(1, hlo, hhi);
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
